lc3b_dmem_responder: RTL and testbench

- Responder end of the LC-3b data-memory port.
- Services d_mem_read / d_mem_write / d_mem_byte_enable requests from the pipeline MEM stage with a fixed, parameterised latency.
- Backed by an internal word-organised SRAM with byte-lane writes.
- Used as the data memory in pipeline simulation, and as the slave side that the future data cache must match cycle-for-cycle.

---
 rtl/lc3b_dmem_responder_pkg.sv | 6 +
 rtl/lc3b_dmem_responder_if.sv | 20 ++
 rtl/lc3b_dmem_array.sv | 25 ++
 rtl/lc3b_dmem_responder.sv | 93 +++++++++
 tb/tb_lc3b_dmem_responder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_dmem_responder_pkg.sv
// lc3b_dmem_responder_pkg: shared LC-3b data-memory types and responder FSM states
package lc3b_dmem_responder_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_RESP} dmem_state_t;
endpackage

// File: rtl/lc3b_dmem_responder_if.sv
// lc3b_dmem_responder_if: LC-3b data-memory request/response bus
interface lc3b_dmem_responder_if;
  import lc3b_dmem_responder_pkg::*;
  logic          d_mem_read;
  logic          d_mem_write;
  lc3b_word      d_mem_address;
  lc3b_word      d_mem_wdata;
  lc3b_mem_wmask d_mem_byte_enable;
  logic          d_mem_resp;
  lc3b_word      d_mem_rdata;
  logic          d_mem_err;
  modport master (
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
    input  d_mem_resp, d_mem_rdata, d_mem_err
  );
  modport slave (
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
    output d_mem_resp, d_mem_rdata, d_mem_err
  );
endinterface

// File: rtl/lc3b_dmem_array.sv
// lc3b_dmem_array: word SRAM with async clear, one read port and one byte-masked write port
module lc3b_dmem_array
  import lc3b_dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output lc3b_word             rdata_o,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  lc3b_word             wdata_i,
  input  lc3b_mem_wmask        wmask_i
);
  lc3b_word mem_q [2**ADDR_BITS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_BITS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      if (wmask_i[0]) mem_q[waddr_i][7:0] <= wdata_i[7:0];
      if (wmask_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
    end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lc3b_dmem_responder.sv
// lc3b_dmem_responder: fixed-latency LC-3b data-memory responder backed by lc3b_dmem_array
module lc3b_dmem_responder
  import lc3b_dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  lc3b_dmem_responder_if.slave mem_if
);
  dmem_state_t          state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d, cur_idx;
  lc3b_word             wdata_q, wdata_d, cur_wdata;
  lc3b_mem_wmask        be_q, be_d, cur_be;
  logic                 rd_q, rd_d, wr_q, wr_d, cur_rd, cur_wr;
  logic                 resp_q, resp_d, err_q, err_d;
  lc3b_word             rdata_q, rdata_d, arr_rdata;
  logic                 idle, to_resp, we;
  // With LATENCY = 1 the commit happens on the accepting edge, so IDLE uses live inputs.
  assign idle      = state_q == DMEM_IDLE;
  assign cur_idx   = idle ? mem_if.d_mem_address[ADDR_BITS:1] : idx_q;
  assign cur_wdata = idle ? mem_if.d_mem_wdata : wdata_q;
  assign cur_be    = idle ? mem_if.d_mem_byte_enable : be_q;
  assign cur_rd    = idle ? mem_if.d_mem_read : rd_q;
  assign cur_wr    = idle ? mem_if.d_mem_write : wr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (idle && (mem_if.d_mem_read || mem_if.d_mem_write)) begin
      idx_d   = cur_idx;
      wdata_d = cur_wdata;
      be_d    = cur_be;
      rd_d    = cur_rd;
      wr_d    = cur_wr;
      cnt_d   = 4'(LATENCY - 1);
      state_d = LATENCY > 1 ? DMEM_BUSY : DMEM_RESP;
    end else if (state_q == DMEM_BUSY) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? DMEM_RESP : DMEM_BUSY;
    end else if (state_q == DMEM_RESP) begin
      state_d = DMEM_IDLE;
    end
    to_resp = state_d == DMEM_RESP && state_q != DMEM_RESP;
    we      = to_resp && cur_wr && !cur_rd;
    resp_d  = to_resp;
    err_d   = to_resp && cur_rd && cur_wr;
    rdata_d = (to_resp && cur_rd && !cur_wr) ? arr_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  lc3b_dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_i (cur_idx),
    .rdata_o (arr_rdata),
    .we_i    (we),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .wmask_i (cur_be)
  );
  assign mem_if.d_mem_resp  = resp_q;
  assign mem_if.d_mem_rdata = rdata_q;
  assign mem_if.d_mem_err   = err_q;
endmodule

// File: tb/tb_lc3b_dmem_responder.sv
// tb_lc3b_dmem_responder: random and directed checks of two responders (LATENCY 2 and 1) against a word-array model
module tb_lc3b_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  lc3b_dmem_responder_if bus0 ();
  lc3b_dmem_responder_if bus1 ();
  lc3b_dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut0 (.clk(clk), .rst_n(rst_n), .mem_if(bus0));
  lc3b_dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .mem_if(bus1));
  logic        resp_w [2];
  logic [15:0] rdata_w [2];
  logic        err_w [2];
  assign resp_w[0] = bus0.d_mem_resp;
  assign resp_w[1] = bus1.d_mem_resp;
  assign rdata_w[0] = bus0.d_mem_rdata;
  assign rdata_w[1] = bus1.d_mem_rdata;
  assign err_w[0] = bus0.d_mem_err;
  assign err_w[1] = bus1.d_mem_err;
  int          lat [2] = '{2, 1};
  logic [15:0] mdl [2][256];
  int          exp_cycle [2] = '{-1, -1};
  logic [15:0] exp_rdata [2];
  logic        exp_err [2];
  logic        exp_rdchk [2];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  // Every cycle: resp only on the predicted cycle, payload right on resp, zero otherwise.
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("resp_timing%0d", d), 16'(resp_w[d]), 16'(cyc == exp_cycle[d]));
      if (resp_w[d]) begin
        if (exp_rdchk[d]) chk($sformatf("rdata%0d", d), rdata_w[d], exp_rdata[d]);
        chk($sformatf("err%0d", d), 16'(err_w[d]), 16'(exp_err[d]));
      end else begin
        chk($sformatf("idle_rdata%0d", d), rdata_w[d], 16'h0000);
        chk($sformatf("idle_err%0d", d), 16'(err_w[d]), 16'h0000);
      end
    end
  task automatic setin(int d, logic rd, logic wr, logic [15:0] a, logic [15:0] wd, logic [1:0] be);
    if (d == 0) begin
      bus0.d_mem_read = rd; bus0.d_mem_write = wr; bus0.d_mem_address = a;
      bus0.d_mem_wdata = wd; bus0.d_mem_byte_enable = be;
    end else begin
      bus1.d_mem_read = rd; bus1.d_mem_write = wr; bus1.d_mem_address = a;
      bus1.d_mem_wdata = wd; bus1.d_mem_byte_enable = be;
    end
  endtask
  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      exp_cycle[d] = -1;
      for (int i = 0; i < 256; i++) mdl[d][i] = 16'h0000;
    end
  endtask
  // Entered and left at #1 after a rising edge; the request is present from that cycle on.
  task automatic txn(input int d, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] be, input int gap, input bit scr,
                     output logic [15:0] got_rdata, output logic got_err, output int ic, output int rc);
    logic [15:0] m;
    int idx;
    bit seen;
    repeat (gap) begin @(posedge clk); #1; end
    setin(d, rd, wr, a, wd, be);
    ic = cyc;
    idx = int'(a[8:1]);
    exp_cycle[d] = ic + lat[d];
    exp_err[d] = rd && wr;
    exp_rdchk[d] = rd;
    exp_rdata[d] = (rd && !wr) ? mdl[d][idx] : 16'h0000;
    if (wr && !rd) begin
      m = {{8{be[1]}}, {8{be[0]}}};
      mdl[d][idx] = (mdl[d][idx] & ~m) | (wd & m);
    end
    seen = 0;
    got_rdata = 16'hxxxx;
    got_err = 1'bx;
    rc = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (scr) setin(d, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
      @(negedge clk);
      if (resp_w[d]) begin
        seen = 1;
        got_rdata = rdata_w[d];
        got_err = err_w[d];
        rc = cyc;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: dut%0d no resp within 40 cycles, got 0 expected 1", d);
    end
    @(posedge clk); #1;
    setin(d, 0, 0, 16'h0000, 16'h0000, 2'b00);
  endtask
  initial begin
    logic [15:0] r, a;
    logic e;
    int ic, rc, ic2, rc2, k;
    clear_model();
    setin(0, 0, 0, 16'h0000, 16'h0000, 2'b00);
    setin(1, 0, 0, 16'h0000, 16'h0000, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", 16'(bus0.d_mem_resp), 16'h0000);
    chk("reset_rdata", bus0.d_mem_rdata, 16'h0000);
    rst_n = 1'b1;
    txn(0, 1, 0, 16'h0010, 16'h0000, 2'b11, 1, 0, r, e, ic, rc);
    chk("t1_latency", 16'(rc - ic), 16'd2);
    chk("t1_rdata", r, 16'h0000);
    chk("t1_err", 16'(e), 16'h0000);
    txn(0, 0, 1, 16'h0020, 16'h1234, 2'b11, 0, 0, r, e, ic, rc);
    chk("t2_wr_latency", 16'(rc - ic), 16'd2);
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 0, 0, r, e, ic, rc);
    chk("t2_rd", r, 16'h1234);
    txn(0, 1, 0, 16'h0021, 16'h0000, 2'b00, 1, 0, r, e, ic, rc);
    chk("t2_rd_odd", r, 16'h1234);
    txn(0, 1, 0, 16'h0220, 16'h0000, 2'b00, 0, 0, r, e, ic, rc);
    chk("t2_rd_alias", r, 16'h1234);
    txn(0, 0, 1, 16'h0020, 16'hABCD, 2'b01, 0, 0, r, e, ic, rc);
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b11, 0, 0, r, e, ic, rc);
    chk("t3_lo_lane", r, 16'h12CD);
    txn(0, 0, 1, 16'h0020, 16'h5500, 2'b10, 0, 0, r, e, ic, rc);
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b11, 0, 0, r, e, ic, rc);
    chk("t3_hi_lane", r, 16'h55CD);
    txn(0, 0, 1, 16'h0020, 16'hFFFF, 2'b00, 0, 0, r, e, ic, rc);
    chk("t3_be00_latency", 16'(rc - ic), 16'd2);
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b11, 0, 0, r, e, ic, rc);
    chk("t3_be00_rd", r, 16'h55CD);
    txn(0, 0, 1, 16'h0050, 16'h4242, 2'b11, 2, 0, r, e, ic, rc);
    txn(0, 1, 0, 16'h0050, 16'h0000, 2'b11, 0, 0, r, e, ic2, rc2);
    chk("t4_spacing_l2", 16'(rc2 - rc), 16'd3);
    chk("t4_rd_l2", r, 16'h4242);
    txn(1, 0, 1, 16'h0050, 16'h9876, 2'b11, 1, 0, r, e, ic, rc);
    chk("t4_latency_l1", 16'(rc - ic), 16'd1);
    txn(1, 1, 0, 16'h0050, 16'h0000, 2'b11, 0, 0, r, e, ic2, rc2);
    chk("t4_spacing_l1", 16'(rc2 - rc), 16'd2);
    chk("t4_rd_l1", r, 16'h9876);
    for (int d = 0; d < 2; d++) begin
      txn(d, 0, 1, 16'h0030, 16'h0777, 2'b11, 1, 0, r, e, ic, rc);
      txn(d, 1, 1, 16'h0030, 16'hFFFF, 2'b11, 0, 0, r, e, ic, rc);
      chk($sformatf("t5_err%0d", d), 16'(e), 16'h0001);
      chk($sformatf("t5_err_rdata%0d", d), r, 16'h0000);
      chk($sformatf("t5_err_latency%0d", d), 16'(rc - ic), 16'(lat[d]));
      txn(d, 1, 0, 16'h0030, 16'h0000, 2'b11, 0, 0, r, e, ic, rc);
      chk($sformatf("t5_after_err%0d", d), r, 16'h0777);
    end
    for (int n = 0; n < 200; n++) begin
      int d, kind;
      d = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      a = 16'($urandom);
      a[8:5] = 4'h0;
      txn(d, kind < 4 || kind == 9, kind >= 4, a, 16'($urandom), 2'($urandom),
          int'($urandom_range(0, 2)), 1, r, e, ic, rc);
    end
    // Reset landing in the RESP cycle of a read of 0x55CD.
    setin(0, 1, 0, 16'h0020, 16'h0000, 2'b11);
    exp_err[0] = 1'b0;
    exp_rdchk[0] = 1'b1;
    exp_rdata[0] = mdl[0][16];
    exp_cycle[0] = cyc + 2;
    @(posedge clk); #1;
    setin(0, 0, 0, 16'h0000, 16'h0000, 2'b00);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("t6_resp_cleared", 16'(bus0.d_mem_resp), 16'h0000);
    chk("t6_rdata_cleared", bus0.d_mem_rdata, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Reset landing in the BUSY cycle of a write: the write must never commit.
    setin(0, 0, 1, 16'h0040, 16'hBEEF, 2'b11);
    k = cyc;
    @(posedge clk); #1;
    rst_n = 1'b0;
    setin(0, 0, 0, 16'h0000, 16'h0000, 2'b00);
    clear_model();
    #1;
    chk("t6_busy_rst_cycle", 16'(cyc - k), 16'd1);
    chk("t6_busy_resp", 16'(bus0.d_mem_resp), 16'h0000);
    chk("t6_busy_err", 16'(bus0.d_mem_err), 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(0, 1, 0, 16'h0040, 16'h0000, 2'b11, 1, 0, r, e, ic, rc);
    chk("t6_no_commit", r, 16'h0000);
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b11, 0, 0, r, e, ic, rc);
    chk("t6_array_cleared", r, 16'h0000);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
